pc_sequencer: RTL

Program-counter sequencer for the 16-bit RISC core. It owns the architectural PC register and drives `PCadjust` each cycle with a select code and a target operand, then registers the returned `adjustedPC`. It arbitrates among stall, interrupt, return, call, branch and sequential fetch, and maintains a small return-address stack (RAS) for calls, returns and interrupt entry.

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/pc_ras.sv | 56 +++++
 rtl/pc_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: select codes, FSM states, default vectors.
package pc_seq_pkg;

    // PCadjust select codes
    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_HOLD = 2'b01,
        PC_ABS  = 2'b10,
        PC_REL  = 2'b11
    } pc_sel_e;

    // Sequencer states
    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        ISR  = 2'b10
    } seq_state_e;

    localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
    localparam logic [15:0] DEF_IRQ_VEC   = 16'h0010;
    localparam int unsigned DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [15:0] i_data,
    output logic [15:0] o_top,
    output logic        o_empty,
    output logic        o_ovf,
    output logic        o_unf
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_top_idx;
    logic          w_full;

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_ovf     = i_push & w_full;
    assign o_unf     = i_pop & o_empty;
    assign w_top_idx = r_wptr - PW'(1);
    assign o_top     = r_mem[w_top_idx];

    // Write pointer and occupancy; the count saturates at DEPTH because a full push wraps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_wptr <= r_wptr + PW'(1);
            if (!w_full) begin
                r_count <= r_count + CW'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_wptr  <= r_wptr - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    // Storage write; stale contents are unreachable once the pointers reset
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: arbitrates redirects, drives PCadjust and owns the PC register.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [15:0] IRQ_VEC   = DEF_IRQ_VEC,
    parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_irq_req,
    input  logic        i_ret_req,
    input  logic        i_call_req,
    input  logic [15:0] i_call_addr,
    input  logic        i_br_req,
    input  logic        i_br_rel,
    input  logic [15:0] i_br_target,
    input  logic [15:0] i_adj_pc,
    output logic [15:0] o_pc,
    output logic [1:0]  o_pc_sel,
    output logic [15:0] o_pc_target,
    output logic        o_fetch_valid,
    output logic        o_flush,
    output logic        o_irq_ack,
    output logic        o_in_service,
    output logic        o_ras_ovf,
    output logic        o_ras_unf
);
    seq_state_e  r_state;
    seq_state_e  w_state_nxt;
    logic [15:0] r_pc;
    logic        r_flush;

    pc_sel_e     w_sel;
    logic [15:0] w_target;
    logic [15:0] w_pc_inc;
    logic        w_accept;
    logic        w_irq_ack;
    logic        w_push;
    logic        w_pop;
    logic [15:0] w_ras_top;
    logic        w_ras_empty;
    logic        w_ras_ovf;
    logic        w_ras_unf;

    assign w_pc_inc = r_pc + 16'd1;

    pc_ras #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_ovf   (w_ras_ovf),
        .o_unf   (w_ras_unf)
    );

    // Request arbitration: irq (RUN only) > ret > call > br > sequential; stall overrides all
    always_comb begin
        w_state_nxt = r_state;
        w_sel       = PC_INC;
        w_target    = '0;
        w_accept    = 1'b0;
        w_irq_ack   = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            BOOT: begin
                w_sel       = PC_HOLD;
                w_state_nxt = RUN;
            end
            RUN, ISR: begin
                if (i_stall) begin
                    w_sel = PC_HOLD;
                end else if (i_irq_req && (r_state == RUN)) begin
                    w_sel       = PC_ABS;
                    w_target    = IRQ_VEC;
                    w_push      = 1'b1;
                    w_irq_ack   = 1'b1;
                    w_accept    = 1'b1;
                    w_state_nxt = ISR;
                end else if (i_ret_req) begin
                    w_sel    = PC_ABS;
                    w_target = w_ras_empty ? RESET_VEC : w_ras_top;
                    w_pop    = 1'b1;
                    w_accept = 1'b1;
                    if (r_state == ISR) begin
                        w_state_nxt = RUN;
                    end
                end else if (i_call_req) begin
                    w_sel    = PC_ABS;
                    w_target = i_call_addr;
                    w_push   = 1'b1;
                    w_accept = 1'b1;
                end else if (i_br_req) begin
                    w_sel    = i_br_rel ? PC_REL : PC_ABS;
                    w_target = i_br_target;
                    w_accept = 1'b1;
                end
            end
            default: begin
                w_sel       = PC_HOLD;
                w_state_nxt = BOOT;
            end
        endcase
    end

    // State, PC and the one-cycle-late flush pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_VEC;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_flush <= w_accept;
            if (o_fetch_valid) begin
                r_pc <= i_adj_pc;
            end
        end
    end

    assign o_pc          = r_pc;
    assign o_pc_sel      = w_sel;
    assign o_pc_target   = w_target;
    assign o_fetch_valid = (r_state == RUN) || (r_state == ISR);
    assign o_flush       = r_flush;
    assign o_irq_ack     = w_irq_ack;
    assign o_in_service  = (r_state == ISR);
    assign o_ras_ovf     = w_ras_ovf;
    assign o_ras_unf     = w_ras_unf;

endmodule
